// File: rtl/stream_latency_meter_pkg.sv
// Shared encodings and width constants for the DDR delay-line latency meter.
package stream_latency_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    localparam int DATA_W_DEF = 48;
    localparam int TS_W_DEF   = 32;
    localparam int DELAY_W    = 32;
    localparam int TOL_W      = 16;
    localparam int MISMATCH_W = 16;
    localparam int GAP_W      = 32;

endpackage

// File: rtl/marker_fifo.sv
// Marker FIFO: holds {timestamp, data} of tagged write samples until the matching read.
// The head is read combinationally so it can be compared on the pop cycle; empty push+pop bypasses.
module marker_fifo #(
    parameter int W     = 80,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         bypass, wr_en, rd_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // When empty, a simultaneous push/pop hands the entry straight through.
    assign bypass = empty_o && push_i && pop_i;
    assign wr_en  = push_i && !bypass && (!full_o || pop_i);
    assign rd_en  = pop_i && !empty_o;

    assign dout_o = bypass ? din_i : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/stream_latency_meter.sv
// Latency/integrity meter for the DDR delay-line path: tags periodic write markers, matches them on read.
// Optional STREAM_LATENCY_MINMAX_EN builds the latency min/max trackers.
module stream_latency_meter
    import stream_latency_meter_pkg::*;
#(
    parameter int              DATA_W        = DATA_W_DEF,
    parameter int              TS_W          = TS_W_DEF,
    parameter int              MARK_INTERVAL = 4096,
    parameter int              MARK_DEPTH    = 16,
    parameter logic [TS_W-1:0] TS_RESET_VAL  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  wr_data_valid,
    input  logic [DATA_W-1:0]     rd_data,
    input  logic                  rd_data_valid,
    input  logic [DELAY_W-1:0]    delay_thread,
    input  logic [TOL_W-1:0]      tolerance,
    output logic [TS_W-1:0]       latency_last,
    output logic                  latency_valid,
    output logic [TS_W-1:0]       latency_min,
    output logic [TS_W-1:0]       latency_max,
    output logic [MISMATCH_W-1:0] mismatch_cnt,
    output logic [GAP_W-1:0]      gap_cnt,
    output logic                  window_err,
    output logic                  overflow,
    output logic                  underflow,
    output logic [1:0]            state
);
    localparam int IDX_W   = $clog2(MARK_INTERVAL);
    localparam int ENTRY_W = TS_W + DATA_W;

    state_e                state_q, state_d;
    logic [TS_W-1:0]       ts_q, ts_d;
    logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
    logic [TS_W-1:0]       lat_last_q, lat_last_d;
    logic                  lat_valid_q, lat_valid_d;
    logic [MISMATCH_W-1:0] mismatch_q, mismatch_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic                  win_err_q, win_err_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic                  active, push, pop, pop_ok, ovf_evt, unf_evt;
    logic                  fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]    head;
    logic [TS_W-1:0]       head_ts, lat;
    logic [DATA_W-1:0]     head_data;
    logic [TS_W:0]         dly_ext, tol_ext, diff, diff_mag;
    logic                  out_of_window;

    assign active = (state_q != ST_FAULT);
    assign push   = active && wr_data_valid && (wr_idx_q == '0);
    assign pop    = active && rd_data_valid && (rd_idx_q == '0);

    marker_fifo #(
        .W     (ENTRY_W),
        .DEPTH (MARK_DEPTH)
    ) u_marker_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   ({ts_q, wr_data}),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_ts   = head[ENTRY_W-1 -: TS_W];
    assign head_data = head[DATA_W-1:0];

    assign ovf_evt = push && fifo_full && !pop;
    assign unf_evt = pop && fifo_empty && !push;
    assign pop_ok  = pop && !unf_evt;

    // Modular subtraction gives the true latency for anything shorter than one ts wrap.
    assign lat      = ts_q - head_ts;
    assign dly_ext  = (TS_W+1)'(delay_thread);
    assign tol_ext  = (TS_W+1)'(tolerance);
    assign diff     = {1'b0, lat} - dly_ext;
    assign diff_mag = diff[TS_W] ? ((TS_W+1)'(0) - diff) : diff;
    assign out_of_window = (diff_mag > tol_ext);

    always_comb begin
        ts_d        = ts_q + TS_W'(1);
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        lat_last_d  = lat_last_q;
        lat_valid_d = pop_ok;
        mismatch_d  = mismatch_q;
        gap_d       = gap_q;
        win_err_d   = win_err_q;
        ovf_d       = ovf_q | ovf_evt;
        unf_d       = unf_q | unf_evt;
        if (active && wr_data_valid) wr_idx_d = wr_idx_q + IDX_W'(1);
        if (active && rd_data_valid) rd_idx_d = rd_idx_q + IDX_W'(1);
        if (pop_ok) begin
            lat_last_d = lat;
            if (out_of_window) win_err_d = 1'b1;
            if ((rd_data != head_data) && (mismatch_q != {MISMATCH_W{1'b1}}))
                mismatch_d = mismatch_q + MISMATCH_W'(1);
        end
        if ((state_q == ST_RUN) && !rd_data_valid && wr_data_valid && (gap_q != {GAP_W{1'b1}}))
            gap_d = gap_q + GAP_W'(1);
    end

    // Overflow can also occur before reads ever start, so IDLE may fault directly.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ovf_evt || unf_evt)  state_d = ST_FAULT;
                else if (rd_data_valid) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (ovf_evt || unf_evt) state_d = ST_FAULT;
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q        <= TS_RESET_VAL;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            lat_last_q  <= '0;
            lat_valid_q <= 1'b0;
            mismatch_q  <= '0;
            gap_q       <= '0;
            win_err_q   <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            ts_q        <= ts_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            lat_last_q  <= lat_last_d;
            lat_valid_q <= lat_valid_d;
            mismatch_q  <= mismatch_d;
            gap_q       <= gap_d;
            win_err_q   <= win_err_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

`ifdef STREAM_LATENCY_MINMAX_EN
    logic [TS_W-1:0] lat_min_q, lat_min_d;
    logic [TS_W-1:0] lat_max_q, lat_max_d;

    always_comb begin
        lat_min_d = lat_min_q;
        lat_max_d = lat_max_q;
        if (pop_ok && (lat < lat_min_q)) lat_min_d = lat;
        if (pop_ok && (lat > lat_max_q)) lat_max_d = lat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_min_q <= '1;
            lat_max_q <= '0;
        end else begin
            lat_min_q <= lat_min_d;
            lat_max_q <= lat_max_d;
        end
    end

    assign latency_min = lat_min_q;
    assign latency_max = lat_max_q;
`else
    assign latency_min = '1;
    assign latency_max = '0;
`endif

    assign latency_last  = lat_last_q;
    assign latency_valid = lat_valid_q;
    assign mismatch_cnt  = mismatch_q;
    assign gap_cnt       = gap_q;
    assign window_err    = win_err_q;
    assign overflow      = ovf_q;
    assign underflow     = unf_q;
    assign state         = state_q;

endmodule

// File: tb/tb_stream_latency_meter.sv
// Bench for stream_latency_meter: a queue-based marker model checked every cycle plus directed literals.
module tb_stream_latency_meter;

    localparam int          DW  = 48;
    localparam int          TW  = 32;
    localparam int          MI  = 4;
    localparam int          MD  = 32;
    localparam logic [31:0] TS0 = 32'hFFFF_FFCE;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] wr_data = '0;
    logic          wr_data_valid = 1'b0;
    logic [DW-1:0] rd_data = '0;
    logic          rd_data_valid = 1'b0;
    logic [31:0]   delay_thread = 32'd100;
    logic [15:0]   tolerance = 16'd0;
    logic [TW-1:0] latency_last, latency_min, latency_max;
    logic          latency_valid, window_err, overflow, underflow;
    logic [15:0]   mismatch_cnt;
    logic [31:0]   gap_cnt;
    logic [1:0]    state;

    always #2 clk = ~clk;

    stream_latency_meter #(
        .DATA_W        (DW),
        .TS_W          (TW),
        .MARK_INTERVAL (MI),
        .MARK_DEPTH    (MD),
        .TS_RESET_VAL  (TS0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_data       (wr_data),
        .wr_data_valid (wr_data_valid),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .delay_thread  (delay_thread),
        .tolerance     (tolerance),
        .latency_last  (latency_last),
        .latency_valid (latency_valid),
        .latency_min   (latency_min),
        .latency_max   (latency_max),
        .mismatch_cnt  (mismatch_cnt),
        .gap_cnt       (gap_cnt),
        .window_err    (window_err),
        .overflow      (overflow),
        .underflow     (underflow),
        .state         (state)
    );

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } mark_t;

    // Model: markers are remembered by the cycle they were written; latency is plain cycle difference.
    mark_t       mq[$];
    int          m_cyc, m_wcnt, m_rcnt, e_state;
    logic [31:0] e_last, e_min, e_max, e_gap;
    logic [15:0] e_mis;
    logic        e_valid, e_win, e_ovf, e_unf;

    int checks = 0;
    int failures = 0;
    int pulse_total = 0;
    int p0;

    logic [DW-1:0] hd [0:511];
    int            hc [0:511];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit    push, pop, pop_ok, bypass, ovf, unf;
        mark_t h;
        int    lat;
        longint d;
        if (rst) begin
            mq.delete();
            m_cyc = 0; m_wcnt = 0; m_rcnt = 0; e_state = 0;
            e_last = 0; e_valid = 0; e_min = 32'hFFFF_FFFF; e_max = 0;
            e_mis = 0; e_gap = 0; e_win = 0; e_ovf = 0; e_unf = 0;
            return;
        end
        e_valid = 0; pop_ok = 0; bypass = 0; ovf = 0; unf = 0; lat = 0;
        h = '{0, '0};
        if (e_state != 2) begin
            push = wr_data_valid && (m_wcnt % MI == 0);
            pop  = rd_data_valid && (m_rcnt % MI == 0);
            if (pop) begin
                if (mq.size() != 0) begin
                    h = mq.pop_front();
                    pop_ok = 1;
                end else if (push) begin
                    h = '{m_cyc, wr_data};
                    pop_ok = 1;
                    bypass = 1;
                end else begin
                    unf = 1;
                end
            end
            if (push && !bypass) begin
                if (mq.size() >= MD) ovf = 1;
                else mq.push_back('{m_cyc, wr_data});
            end
            if (pop_ok) begin
                lat = m_cyc - h.cyc;
                e_valid = 1;
                e_last = 32'(lat);
                if (rd_data != h.data) e_mis++;
                d = longint'(lat) - longint'(delay_thread);
                if (d < 0) d = -d;
                if (d > longint'(tolerance)) e_win = 1;
                if (32'(lat) < e_min) e_min = 32'(lat);
                if (32'(lat) > e_max) e_max = 32'(lat);
            end
            if (e_state == 1 && !rd_data_valid && wr_data_valid) e_gap++;
            if (ovf) e_ovf = 1;
            if (unf) e_unf = 1;
            if (ovf || unf) e_state = 2;
            else if (e_state == 0 && rd_data_valid) e_state = 1;
            if (wr_data_valid) m_wcnt++;
            if (rd_data_valid) m_rcnt++;
        end
        m_cyc++;
    endtask

    task automatic compare_cycle();
        logic [31:0] xmin, xmax;
`ifdef STREAM_LATENCY_MINMAX_EN
        xmin = e_min;
        xmax = e_max;
`else
        xmin = 32'hFFFF_FFFF;
        xmax = 32'h0;
`endif
        check("latency_valid", 64'(latency_valid), 64'(e_valid));
        check("latency_last", 64'(latency_last), 64'(e_last));
        check("latency_min", 64'(latency_min), 64'(xmin));
        check("latency_max", 64'(latency_max), 64'(xmax));
        check("mismatch_cnt", 64'(mismatch_cnt), 64'(e_mis));
        check("gap_cnt", 64'(gap_cnt), 64'(e_gap));
        check("window_err", 64'(window_err), 64'(e_win));
        check("overflow", 64'(overflow), 64'(e_ovf));
        check("underflow", 64'(underflow), 64'(e_unf));
        check("state", 64'(state), 64'(e_state));
        if (latency_valid === 1'b1) pulse_total++;
    endtask

    // Sample outputs at the falling edge, fold in the inputs the last rising edge saw, compare.
    task automatic cycle();
        @(negedge clk);
        model_step();
        compare_cycle();
    endtask

    task automatic reset_literals(input string tag);
        check({tag, "_rst_last"}, 64'(latency_last), 64'h0);
        check({tag, "_rst_valid"}, 64'(latency_valid), 64'h0);
        check({tag, "_rst_min"}, 64'(latency_min), 64'hFFFF_FFFF);
        check({tag, "_rst_max"}, 64'(latency_max), 64'h0);
        check({tag, "_rst_mis"}, 64'(mismatch_cnt), 64'h0);
        check({tag, "_rst_gap"}, 64'(gap_cnt), 64'h0);
        check({tag, "_rst_win"}, 64'(window_err), 64'h0);
        check({tag, "_rst_ovf"}, 64'(overflow), 64'h0);
        check({tag, "_rst_unf"}, 64'(underflow), 64'h0);
        check({tag, "_rst_state"}, 64'(state), 64'h0);
    endtask

    // Asynchronous reset asserted between clock edges, while the streams are still live.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        reset_literals(tag);
        wr_data_valid = 1'b0;
        rd_data_valid = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    // Write stream continuous (if enabled); read stream replays it 'dly' cycles later,
    // optionally stalled for stall_len cycles and with bit 0 of read sample flip_at inverted.
    task automatic run_phase(input int ncyc, input int dly, input bit wr_on, input bit rd_on,
                             input int stall_at, input int stall_len, input int flip_at);
        int wn = 0;
        int rp = 0;
        p0 = pulse_total;
        for (int c = 0; c < ncyc; c++) begin
            cycle();
            wr_data_valid = wr_on;
            wr_data = {16'($urandom), $urandom};
            if (wr_on) begin
                hd[wn] = wr_data;
                hc[wn] = c;
                wn++;
            end
            rd_data_valid = 1'b0;
            rd_data = {16'($urandom), $urandom};
            if (rd_on && !(c >= stall_at && c < stall_at + stall_len) && rp < wn && hc[rp] + dly <= c) begin
                rd_data_valid = 1'b1;
                rd_data = hd[rp];
                if (rp == flip_at) rd_data[0] = ~rd_data[0];
                rp++;
            end
        end
        cycle();
    endtask

    initial begin
        cycle();
        cycle();
        rst = 1'b0;

        // Nominal: 100-cycle delay line, crossing the ts wrap ~50 cycles after reset.
        delay_thread = 32'd100; tolerance = 16'd0;
        run_phase(200, 100, 1, 1, -10, 0, -1);
        check("p1_pulses", 64'(pulse_total - p0), 64'd25);
        check("p1_last", 64'(latency_last), 64'd100);
        check("p1_win", 64'(window_err), 64'd0);
        check("p1_mis", 64'(mismatch_cnt), 64'd0);
        check("p1_state", 64'(state), 64'd1);
`ifdef STREAM_LATENCY_MINMAX_EN
        check("p1_min", 64'(latency_min), 64'd100);
        check("p1_max", 64'(latency_max), 64'd100);
`endif
        do_reset("p1");

        // Corrupted marker sample.
        run_phase(200, 100, 1, 1, -10, 0, 20);
        check("p2_mis", 64'(mismatch_cnt), 64'd1);
        check("p2_last", 64'(latency_last), 64'd100);
        do_reset("p2");

        // Window violation, then boundary tolerance that just admits it.
        delay_thread = 32'd90; tolerance = 16'd5;
        run_phase(101, 100, 1, 1, -10, 0, -1);
        check("p3_pulses", 64'(pulse_total - p0), 64'd1);
        check("p3_win", 64'(window_err), 64'd1);
        do_reset("p3");
        tolerance = 16'd10;
        run_phase(101, 100, 1, 1, -10, 0, -1);
        check("p4_win", 64'(window_err), 64'd0);
        check("p4_last", 64'(latency_last), 64'd100);
        do_reset("p4");

        // Three-cycle read stall while writes continue.
        delay_thread = 32'd100; tolerance = 16'd1000;
        run_phase(200, 100, 1, 1, 150, 3, -1);
        check("p5_gap", 64'(gap_cnt), 64'd3);
        check("p5_last", 64'(latency_last), 64'd103);
        do_reset("p5");

        // Reads withheld: 33rd marker overflows the FIFO, then everything freezes.
        run_phase(140, 100, 1, 0, -10, 0, -1);
        check("p6_ovf", 64'(overflow), 64'd1);
        check("p6_state", 64'(state), 64'd2);
        check("p6_unf", 64'(underflow), 64'd0);
        run_phase(20, 0, 1, 1, 5, 5, -1);
        check("p6b_pulses", 64'(pulse_total - p0), 64'd0);
        check("p6b_gap", 64'(gap_cnt), 64'd0);
        check("p6b_state", 64'(state), 64'd2);
        do_reset("p6");

        // Read marker with nothing written: underflow.
        p0 = pulse_total;
        for (int c = 0; c < 4; c++) begin
            cycle();
            wr_data_valid = 1'b0;
            rd_data_valid = 1'b1;
            rd_data = {16'($urandom), $urandom};
        end
        cycle();
        check("p7_unf", 64'(underflow), 64'd1);
        check("p7_state", 64'(state), 64'd2);
        check("p7_pulses", 64'(pulse_total - p0), 64'd0);
        do_reset("p7");

        // Zero delay: every marker goes through the empty-FIFO bypass.
        delay_thread = 32'd0; tolerance = 16'd0;
        run_phase(40, 0, 1, 1, -10, 0, -1);
        check("p8_pulses", 64'(pulse_total - p0), 64'd10);
        check("p8_last", 64'(latency_last), 64'd0);
        check("p8_win", 64'(window_err), 64'd0);
        check("p8_state", 64'(state), 64'd1);
`ifdef STREAM_LATENCY_MINMAX_EN
        check("p8_max", 64'(latency_max), 64'd0);
`endif
        do_reset("p8");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_latency_meter.md
# stream_latency_meter

Measures end-to-end latency and integrity of the DDR delay-line path. Sits beside the DDR write/read wrapper at top level: it taps the 48-bit write stream entering the wrapper and the 48-bit read stream leaving it. It tags periodic marker samples on the write side, matches them on the read side, and reports cycle latency, data mismatches, read-stream gaps and window violations against the programmed delay. Its outputs feed the ILA/VIO debug probes.

## Interface
- `DATA_W`, 48: sample width.
- `TS_W`, 32: timestamp and latency width.
- `MARK_INTERVAL`, 4096: valid samples between markers; power of 2, ≥2.
- `MARK_DEPTH`, 16: marker FIFO depth; power of 2.
- `clk`  in  1  single clock for all logic (250 MHz user clock).
- `rst`  in  1  asynchronous, active-high reset.
- `wr_data`  in  DATA_W  write-side sample.
- `wr_data_valid`  in  1  write-side qualifier.
- `rd_data`  in  DATA_W  read-side sample.
- `rd_data_valid`  in  1  read-side qualifier.
- `delay_thread`  in  32  expected latency in cycles.
- `tolerance`  in  16  allowed ± deviation from `delay_thread`.
- `latency_last`  out  TS_W  most recent measured latency.
- `latency_valid`  out  1  one-cycle pulse when `latency_last` updates.
- `latency_min` / `latency_max`  out  TS_W  extremes since reset.
- `mismatch_cnt`  out  16  marker data mismatches, saturating.
- `gap_cnt`  out  32  read gap cycles in RUN, saturating.
- `window_err`  out  1  sticky: a latency fell outside the window.
- `overflow`  out  1  sticky: marker push while full.
- `underflow`  out  1  sticky: marker pop while empty.
- `state`  out  2  0=IDLE, 1=RUN, 2=FAULT.

## Operation
- `ts`: free-running TS_W counter that increments every cycle and wraps.
- Write side:
  - `wr_idx` counts valid write samples modulo MARK_INTERVAL.
  - When `wr_data_valid` is high and `wr_idx==0`, push {`ts`, `wr_data`} into the marker FIFO.
- Read side:
  - `rd_idx` counts valid read samples modulo MARK_INTERVAL.
  - When `rd_data_valid` is high and `rd_idx==0`, pop the FIFO head and compute latency = `ts − head_ts`, modulo 2^TS_W. The result is correct for any true latency < 2^TS_W.
  - If `rd_data != head_data`, increment `mismatch_cnt`.
  - If |latency − `delay_thread`| > `tolerance`, set `window_err`. Compute the difference in TS_W+1 bits, signed.
- State machine:
  - IDLE → RUN on the first `rd_data_valid`.
  - RUN → FAULT on overflow or underflow.
  - FAULT is held until `rst`.
- Gap: in RUN, any cycle with `rd_data_valid==0` while `wr_data_valid==1` increments `gap_cnt`.
- Boundaries:
  - Push when full and no pop that cycle: drop the push, set `overflow`.
  - Push and pop in the same cycle are both legal when full, and also when empty.
  - When empty with a simultaneous push, the pop returns the pushed entry (FIFO bypass).
  - Pop when empty with no push: set `underflow`, no latency update, `latency_valid` stays low.
  - In FAULT: pushes and pops are ignored; counters freeze; `ts` keeps running.
- Reset mid-operation asynchronously clears everything, including the FIFO pointers.

## Timing
- Reset values:
  - `latency_min` = all-ones.
  - `state` = IDLE.
  - All other outputs and counters = 0.
- `latency_valid`, `latency_last`, min/max and `mismatch_cnt` update 1 cycle after the qualifying read sample (registered).
- `window_err` sets in the same cycle as the `latency_valid` pulse.
- `gap_cnt`, `overflow`, `underflow` and `state` are registered and update 1 cycle after the causing cycle.
- Latency is reported exactly: a sample written at cycle N and read at cycle N+D reports D.
- Inputs are not retimed; both streams must be synchronous to `clk`.

## Configuration
- `STREAM_LATENCY_MINMAX_EN`
  - Defined: `latency_min` and `latency_max` track the extremes of every reported latency.
  - Undefined: the min/max comparators are not built; `latency_min` is tied to all-ones and `latency_max` to 0.

## Structure
- Shared package holds:
  - state encodings IDLE/RUN/FAULT;
  - default widths `DATA_W` and `TS_W`;
  - the saturating-increment width constants.
- One sub-module: `marker_fifo`.
  - Synchronous FIFO, `MARK_DEPTH` × (TS_W+DATA_W), with full/empty flags and empty bypass.
  - Same `clk`/`rst`.

## Test plan
- MARK_INTERVAL=4, continuous writes from reset, reads are the write stream delayed 100 cycles, `delay_thread`=100, `tolerance`=0:
  - `latency_valid` pulses every 4 cycles with `latency_last`=100;
  - `window_err`=0, `mismatch_cnt`=0;
  - `state`=RUN.
- Same setup, one marker read sample's bit 0 inverted → `mismatch_cnt`=1, latency still 100.
- Delay 100, `delay_thread`=90, `tolerance`=5 → `window_err`=1 on the first pulse; with `tolerance`=10 → stays 0.
- MARK_DEPTH=4, MARK_INTERVAL=4, reads withheld for 20 write samples (5 markers) → `overflow`=1, `state`=FAULT, counters frozen.
- Read valid deasserted for 3 cycles mid-stream while writes continue → `gap_cnt`=3.
- Pre-load `ts` near 2^32−50, delay 100 → `latency_last`=100 across the wrap; assert `rst` mid-stream → all outputs return to reset values.
